// File: rtl/exec_unit.sv
// Single-cycle execution unit: 4x16-bit register file, fixed 16-entry program ROM,
// read-only data memory. Optional instruction counter under EXEC_UNIT_TRACE_EN.
module exec_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  InstrAddr,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    input  logic [7:0]  Z,
    output logic [2:0]  ALUFlags,
    output logic [15:0] Result,
    output logic        Done
`ifdef EXEC_UNIT_TRACE_EN
    ,
    output logic [15:0] InstrCount
`endif
);

    typedef enum logic [2:0] {
        OP_NOP,
        OP_LD,
        OP_LDI,
        OP_ADD,
        OP_SUB,
        OP_DEC,
        OP_ST
    } op_e;

    op_e         op;
    logic [1:0]  dst;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [2:0]  offset;
    logic [15:0] imm;

    logic [15:0] regs_q [4];
    logic [15:0] regs_d [4];
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;

    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] alu_a, alu_b, alu_res;
    logic        alu_valid;

    // Instruction ROM decode
    always_comb begin
        op     = OP_NOP;
        dst    = 2'd0;
        ra     = 2'd0;
        rb     = 2'd2;
        offset = 3'd0;
        imm    = '0;
        case (InstrAddr)
            8'h00: begin op = OP_LDI; dst = 2'd3; imm = 16'd0; end
            8'h01: begin op = OP_LD;  dst = 2'd0; offset = 3'd0; end
            8'h02: begin op = OP_LD;  dst = 2'd1; offset = 3'd4; end
            8'h03: begin op = OP_LD;  dst = 2'd2; offset = 3'd1; end
            8'h04: begin op = OP_ADD; dst = 2'd0; ra = 2'd0; end
            8'h05: begin op = OP_DEC; dst = 2'd1; ra = 2'd1; end
            8'h06: begin op = OP_LD;  dst = 2'd1; offset = 3'd5; end
            8'h07: begin op = OP_LD;  dst = 2'd2; offset = 3'd2; end
            8'h08: begin op = OP_SUB; dst = 2'd0; ra = 2'd0; end
            8'h09: begin op = OP_DEC; dst = 2'd1; ra = 2'd1; end
            8'h0A: begin op = OP_LD;  dst = 2'd1; offset = 3'd6; end
            8'h0B: begin op = OP_LD;  dst = 2'd2; offset = 3'd3; end
            8'h0C: begin op = OP_ADD; dst = 2'd0; ra = 2'd0; end
            8'h0D: begin op = OP_DEC; dst = 2'd1; ra = 2'd1; end
            8'h0E: begin op = OP_LDI; dst = 2'd1; imm = 16'd1; end
            8'h0F: begin op = OP_ST; end
            default: op = OP_NOP;
        endcase
    end

    // Data memory, word-addressed as R3 + offset
    always_comb begin
        mem_addr = regs_q[3] + {13'd0, offset};
        case (mem_addr)
            16'd0:   mem_rdata = 16'd4;
            16'd1:   mem_rdata = {{8{X[7]}}, X};
            16'd2:   mem_rdata = {{8{Y[7]}}, Y};
            16'd3:   mem_rdata = {{8{Z[7]}}, Z};
            16'd4:   mem_rdata = 16'd12;
            16'd5:   mem_rdata = 16'd33;
            16'd6:   mem_rdata = 16'd22;
            default: mem_rdata = '0;
        endcase
    end

    always_comb begin
        alu_a     = regs_q[ra];
        alu_b     = (op == OP_DEC) ? 16'd1 : regs_q[rb];
        alu_res   = (op == OP_ADD) ? (alu_a + alu_b) : (alu_a - alu_b);
        alu_valid = (op == OP_ADD) || (op == OP_SUB) || (op == OP_DEC);
        ALUFlags  = '0;
        if (alu_valid) begin
            ALUFlags[2] = (alu_res == 16'd0);
            ALUFlags[1] = !alu_res[15] && (alu_res != 16'd0);
            ALUFlags[0] = alu_res[15];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        result_d = result_q;
        done_d   = done_q;
        case (op)
            OP_LD:                  regs_d[dst] = mem_rdata;
            OP_LDI:                 regs_d[dst] = imm;
            OP_ADD, OP_SUB, OP_DEC: regs_d[dst] = alu_res;
            OP_ST: begin
                result_d = regs_q[0];
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Done   = done_q;

`ifdef EXEC_UNIT_TRACE_EN
    logic [15:0] count_q, count_d;

    // Counts ROM-resident addresses only, saturating
    always_comb begin
        count_d = count_q;
        if ((InstrAddr < 8'h10) && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign InstrCount = count_q;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: the bench plays the sequencing FSM, branching on
// ALUFlags at the decrement steps, and checks results against hand-computed values.
module tb_exec_unit;

    logic        CLK;
    logic        Reset;
    logic [7:0]  InstrAddr;
    logic [7:0]  X, Y, Z;
    logic [2:0]  ALUFlags;
    logic [15:0] Result;
    logic        Done;
`ifdef EXEC_UNIT_TRACE_EN
    logic [15:0] InstrCount;
    logic [15:0] cnt_before;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] flags_seen;
    int c4, c8, c12;

    exec_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .InstrAddr (InstrAddr),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .ALUFlags  (ALUFlags),
        .Result    (Result),
        .Done      (Done)
`ifdef EXEC_UNIT_TRACE_EN
        ,
        .InstrCount(InstrCount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an address, capture the combinational flags, then clock it in
    task automatic exec(input logic [7:0] a);
        InstrAddr  = a;
        #1;
        flags_seen = ALUFlags;
        @(posedge CLK);
        #1;
    endtask

    task automatic loop(input logic [7:0] body, input logic [7:0] dec, output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            exec(body);
            n++;
            exec(dec);
            if (flags_seen == 3'b100) break;
        end
    endtask

    // Runs 00..0E; operands are scrambled after their load to show they are not re-read
    task automatic run_prog(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                            output int n4, output int n8, output int n12);
        X = x; Y = y; Z = z;
        exec(8'h00); exec(8'h01); exec(8'h02); exec(8'h03);
        X = ~x;
        loop(8'h04, 8'h05, n4);
        exec(8'h06); exec(8'h07);
        Y = ~y;
        loop(8'h08, 8'h09, n8);
        exec(8'h0A); exec(8'h0B);
        Z = ~z;
        loop(8'h0C, 8'h0D, n12);
        exec(8'h0E);
    endtask

    initial begin
        Reset = 1'b0;
        InstrAddr = 8'h20;
        X = '0; Y = '0; Z = '0;
        #2;
        chk("reset_result", Result, 16'h0000);
        chk("reset_done", {15'd0, Done}, 16'd0);
        chk("reset_flags_nop", {13'd0, ALUFlags}, 16'd0);
        InstrAddr = 8'h04;
        #1;
        chk("reset_flags_add", {13'd0, ALUFlags}, 16'd4);
`ifdef EXEC_UNIT_TRACE_EN
        chk("reset_count", InstrCount, 16'd0);
`endif
        #9;
        Reset = 1'b1;

        // Flag behaviour from a clean register file
        exec(8'h05);
        chk("flags_dec_neg", {13'd0, flags_seen}, 16'd1);
        exec(8'h0E);
        chk("flags_ldi", {13'd0, flags_seen}, 16'd0);
        exec(8'h05);
        chk("flags_dec_zero", {13'd0, flags_seen}, 16'd4);
        exec(8'h01);
        chk("flags_load", {13'd0, flags_seen}, 16'd0);
        exec(8'h04);
        chk("flags_add_pos", {13'd0, flags_seen}, 16'd2);
        chk("no_store_result", Result, 16'h0000);
        chk("no_store_done", {15'd0, Done}, 16'd0);

        run_prog(8'd1, 8'd0, 8'd0, c4, c8, c12);
        chk("p1_done_before", {15'd0, Done}, 16'd0);
        exec(8'h0F);
        chk("p1_flags_store", {13'd0, flags_seen}, 16'd0);
        chk("p1_result", Result, 16'h0010);
        chk("p1_done", {15'd0, Done}, 16'd1);
        exec(8'h0F);
        chk("p1_restore_result", Result, 16'h0010);
        chk("p1_restore_done", {15'd0, Done}, 16'd1);

        run_prog(8'd2, 8'd1, 8'd3, c4, c8, c12);
        chk("p2_done_sticky", {15'd0, Done}, 16'd1);
        chk("p2_result_held", Result, 16'h0010);
        exec(8'h0F);
        chk("p2_result", Result, 16'h003D);

        run_prog(8'd0, 8'd1, 8'd0, c4, c8, c12);
        exec(8'h0F);
        chk("p3_result", Result, 16'hFFE3);

        run_prog(8'd127, 8'h80, 8'd127, c4, c8, c12);
        exec(8'h0F);
        chk("p4_result", Result, 16'h2162);
        chk("p4_iter04", 16'(c4), 16'd12);
        chk("p4_iter08", 16'(c8), 16'd33);
        chk("p4_iter0c", 16'(c12), 16'd22);

        // Out-of-ROM addresses are NOPs
`ifdef EXEC_UNIT_TRACE_EN
        cnt_before = InstrCount;
`endif
        for (int i = 0; i < 5; i++) begin
            exec(8'h20);
            chk("nop_flags", {13'd0, flags_seen}, 16'd0);
        end
        chk("nop_done", {15'd0, Done}, 16'd1);
        chk("nop_result", Result, 16'h2162);
`ifdef EXEC_UNIT_TRACE_EN
        chk("nop_count", InstrCount, cnt_before);
`endif
        X = 8'd5;
        exec(8'h0F);
        chk("nop_regs_kept", Result, 16'h2162);
`ifdef EXEC_UNIT_TRACE_EN
        chk("count_step", InstrCount, cnt_before + 16'd1);
`endif

        // Reset mid-program at address 08
        X = 8'd1; Y = 8'd0; Z = 8'd0;
        exec(8'h00); exec(8'h01); exec(8'h02); exec(8'h03);
        exec(8'h04); exec(8'h05); exec(8'h06); exec(8'h07);
        InstrAddr = 8'h08;
        #2;
        Reset = 1'b0;
        #1;
        chk("midrst_result", Result, 16'h0000);
        chk("midrst_done", {15'd0, Done}, 16'd0);
`ifdef EXEC_UNIT_TRACE_EN
        chk("midrst_count", InstrCount, 16'd0);
`endif
        #3;
        Reset = 1'b1;
        run_prog(8'd1, 8'd0, 8'd0, c4, c8, c12);
        chk("rerun_done_before", {15'd0, Done}, 16'd0);
        exec(8'h0F);
        chk("rerun_result", Result, 16'h0010);
        chk("rerun_done", {15'd0, Done}, 16'd1);
        chk("rerun_iter04", 16'(c4), 16'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
